// File: rtl/pong_game_ctrl.sv
// Pong frame controller: detects vertical blanking and runs a four-step update
// sequence (paddles, ball, collisions, scoring) once per frame.
module pong_game_ctrl #(
    parameter int H_DISP       = 640,
    parameter int V_DISP       = 480,
    parameter int PADDLE_H     = 72,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_X_L   = 32,
    parameter int PADDLE_X_R   = 600,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SPEED   = 2,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up_l,
    input  logic       btn_dn_l,
    input  logic       btn_up_r,
    input  logic       btn_dn_r,
    input  logic       btn_start,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} game_t;
    typedef enum logic [2:0] {SEQ_IDLE, S_PAD, S_BALL, S_COLL, S_SCORE} seq_t;

    localparam logic [10:0] PAD_MAX   = 11'(V_DISP - PADDLE_H);
    localparam logic [10:0] BALL_YMAX = 11'(V_DISP - BALL_SIZE);
    localparam logic [10:0] STEP      = 11'(PADDLE_STEP);
    localparam logic [10:0] SPD       = 11'(BALL_SPEED);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] PH        = 11'(PADDLE_H);
    localparam logic [10:0] HD        = 11'(H_DISP);
    localparam logic [10:0] L_X       = 11'(PADDLE_X_L);
    localparam logic [10:0] L_FACE    = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0] R_X       = 11'(PADDLE_X_R);
    localparam logic [10:0] R_BACK    = 11'(PADDLE_X_R + PADDLE_W);
    localparam logic [9:0]  L_STOP    = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [9:0]  R_STOP    = 10'(PADDLE_X_R - BALL_SIZE);
    localparam logic [9:0]  PAD_HOME  = 10'((V_DISP - PADDLE_H) / 2);
    localparam logic [9:0]  BALL_X0   = 10'((H_DISP - BALL_SIZE) / 2);
    localparam logic [9:0]  BALL_Y0   = 10'((V_DISP - BALL_SIZE) / 2);
    localparam logic [9:0]  BLANK_ROW = 10'(V_DISP);
    localparam logic [3:0]  WIN_SC    = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_END = 8'(SERVE_FRAMES - 1);

    function automatic logic [10:0] pad_move(input logic [9:0] y, input logic up,
                                             input logic dn);
        logic [10:0] w;
        logic [10:0] r;
        w = {1'b0, y};
        r = w;
        if (up && !dn) begin
            r = (w < STEP) ? 11'd0 : w - STEP;
        end else if (dn && !up) begin
            r = (w + STEP > PAD_MAX) ? PAD_MAX : w + STEP;
        end
        return r;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    game_t       game;
    seq_t        seq;
    logic        frame_tick_p0;
    logic        start_q;
    logic [7:0]  serve_cnt;
    logic        dx_right;
    logic        dy_down;
    logic        pt_l;
    logic        pt_r;

    logic [10:0] pl_nx, pr_nx, bx_w, by_w, pl_w, pr_w, nx, ny;
    logic        ndy, miss_l, miss_r, hit_l, hit_r;
    logic [3:0]  sl_inc, sr_inc;
    logic        unused_hi;

    always_comb begin
        pl_nx  = pad_move(paddle_l_y, btn_up_l, btn_dn_l);
        pr_nx  = pad_move(paddle_r_y, btn_up_r, btn_dn_r);
        bx_w   = {1'b0, ball_x};
        by_w   = {1'b0, ball_y};
        pl_w   = {1'b0, paddle_l_y};
        pr_w   = {1'b0, paddle_r_y};
        sl_inc = sat_inc(score_l);
        sr_inc = sat_inc(score_r);

        miss_l = !dx_right && (bx_w < SPD);
        miss_r = dx_right && (bx_w + BSZ + SPD > HD);
        nx     = dx_right ? bx_w + SPD : bx_w - SPD;
        ny     = by_w;
        ndy    = dy_down;
        // A wall bounce pins the ball to the wall for this frame instead of stepping.
        if (dy_down) begin
            if (by_w + SPD > BALL_YMAX) begin
                ny  = BALL_YMAX;
                ndy = 1'b0;
            end else begin
                ny = by_w + SPD;
            end
        end else begin
            if (by_w < SPD) begin
                ny  = 11'd0;
                ndy = 1'b1;
            end else begin
                ny = by_w - SPD;
            end
        end

        hit_l = !dx_right && (bx_w <= L_FACE) && (bx_w + BSZ > L_X) &&
                (by_w + BSZ > pl_w) && (by_w < pl_w + PH);
        hit_r = dx_right && (bx_w + BSZ >= R_X) && (bx_w < R_BACK) &&
                (by_w + BSZ > pr_w) && (by_w < pr_w + PH);
    end

    assign unused_hi = ^{pl_nx[10], pr_nx[10], nx[10], ny[10]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            game          <= IDLE;
            seq           <= SEQ_IDLE;
            frame_tick_p0 <= 1'b0;
            start_q       <= 1'b0;
            serve_cnt     <= 8'd0;
            paddle_l_y    <= PAD_HOME;
            paddle_r_y    <= PAD_HOME;
            ball_x        <= BALL_X0;
            ball_y        <= BALL_Y0;
            dx_right      <= 1'b1;
            dy_down       <= 1'b1;
            pt_l          <= 1'b0;
            pt_r          <= 1'b0;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            game_over     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Stage p0: frame tick at the first blanking line, pixel 0.
            frame_tick_p0 <= p_tick && (pixel_x == 10'd0) && (pixel_y == BLANK_ROW);
            start_q       <= btn_start;

            case (seq)
                SEQ_IDLE: begin
                    if (frame_tick_p0 && (game == SERVE || game == PLAY)) begin
                        seq  <= S_PAD;
                        busy <= 1'b1;
                    end
                    if ((game == IDLE || game == OVER) && btn_start && !start_q) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_cnt <= 8'd0;
                        game_over <= 1'b0;
                        game      <= SERVE;
                    end
                end
                S_PAD: begin
                    paddle_l_y <= pl_nx[9:0];
                    paddle_r_y <= pr_nx[9:0];
                    seq        <= S_BALL;
                end
                S_BALL: begin
                    if (game == PLAY) begin
                        if (miss_l) begin
                            pt_r <= 1'b1;
                        end else if (miss_r) begin
                            pt_l <= 1'b1;
                        end else begin
                            ball_x  <= nx[9:0];
                            ball_y  <= ny[9:0];
                            dy_down <= ndy;
                        end
                    end
                    seq <= S_COLL;
                end
                S_COLL: begin
                    if (game == PLAY) begin
                        if (hit_l) begin
                            ball_x   <= L_STOP;
                            dx_right <= 1'b1;
                        end else if (hit_r) begin
                            ball_x   <= R_STOP;
                            dx_right <= 1'b0;
                        end
                    end
                    seq <= S_SCORE;
                end
                S_SCORE: begin
                    seq  <= SEQ_IDLE;
                    busy <= 1'b0;
                    if (game == SERVE) begin
                        if (serve_cnt == SERVE_END) begin
                            serve_cnt <= 8'd0;
                            game      <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 8'd1;
                        end
                    end else if (pt_l || pt_r) begin
                        // Re-serve toward the player who just lost the point.
                        ball_x   <= BALL_X0;
                        ball_y   <= BALL_Y0;
                        dx_right <= pt_l;
                        pt_l     <= 1'b0;
                        pt_r     <= 1'b0;
                        if (pt_l) begin
                            score_l <= sl_inc;
                        end else begin
                            score_r <= sr_inc;
                        end
                        if ((pt_l && sl_inc == WIN_SC) || (!pt_l && sr_inc == WIN_SC)) begin
                            game      <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            game <= SERVE;
                        end
                    end
                end
                default: begin
                    seq  <= SEQ_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a frame model feeds a scoreboard checked whenever busy
// drops, plus directed checks at the points of interest.
module tb_pong_game_ctrl;

    typedef struct packed {
        logic [9:0] pl;
        logic [9:0] pr;
        logic [9:0] bx;
        logic [9:0] by;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } snap_t;

    localparam int G_IDLE = 0, G_SERVE = 1, G_PLAY = 2, G_OVER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick;
    logic [9:0] pixel_x, pixel_y;
    logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r, btn_start;
    logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic       game_over, busy;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .btn_up_l(btn_up_l), .btn_dn_l(btn_dn_l), .btn_up_r(btn_up_r), .btn_dn_r(btn_dn_r),
        .btn_start(btn_start), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    busy_pulses = 0;
    snap_t sb_q[$];

    int m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_game, m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pl = 204; m_pr = 204; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_game = G_IDLE; m_cnt = 0;
    endtask

    task automatic model_start();
        if (m_game == G_IDLE || m_game == G_OVER) begin
            m_sl = 0; m_sr = 0; m_cnt = 0; m_game = G_SERVE;
        end
    endtask

    function automatic int move_pad(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 408) ? 408 : y + 4;
        return y;
    endfunction

    task automatic model_frame(input bit ul, input bit dl, input bit ur, input bit dr);
        int  yy;
        bit  point_l, point_r;
        point_l = 0;
        point_r = 0;
        m_pl = move_pad(m_pl, ul, dl);
        m_pr = move_pad(m_pr, ur, dr);
        if (m_game == G_PLAY) begin
            if (m_dx < 0 && m_bx < 2) point_r = 1;
            else if (m_dx > 0 && m_bx + 10 > 640) point_l = 1;
            else begin
                m_bx = m_bx + 2 * m_dx;
                yy = m_by + 2 * m_dy;
                if (yy < 0) begin m_by = 0; m_dy = 1; end
                else if (yy > 472) begin m_by = 472; m_dy = -1; end
                else m_by = yy;
            end
            if (m_dx < 0 && m_bx <= 40 && m_bx + 8 > 32 && m_by + 8 > m_pl && m_by < m_pl + 72) begin
                m_bx = 40; m_dx = 1;
            end else if (m_dx > 0 && m_bx + 8 >= 600 && m_bx < 608 &&
                         m_by + 8 > m_pr && m_by < m_pr + 72) begin
                m_bx = 592; m_dx = -1;
            end
            if (point_l || point_r) begin
                if (point_l) m_sl = (m_sl == 15) ? 15 : m_sl + 1;
                else         m_sr = (m_sr == 15) ? 15 : m_sr + 1;
                m_bx = 316; m_by = 236;
                m_dx = point_l ? 1 : -1;
                m_game = ((point_l && m_sl == 9) || (point_r && m_sr == 9)) ? G_OVER : G_SERVE;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 60) begin m_game = G_PLAY; m_cnt = 0; end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.pl = 10'(m_pl); s.pr = 10'(m_pr); s.bx = 10'(m_bx); s.by = 10'(m_by);
        s.sl = 4'(m_sl);  s.sr = 4'(m_sr);  s.go = (m_game == G_OVER);
        return s;
    endfunction

    task automatic do_tick(input bit ul, input bit dl, input bit ur, input bit dr);
        btn_up_l = ul; btn_dn_l = dl; btn_up_r = ur; btn_dn_r = dr;
        if (m_game == G_SERVE || m_game == G_PLAY) begin
            model_frame(ul, dl, ur, dr);
            sb_q.push_back(model_snap());
        end
        pixel_x = 10'd0; pixel_y = 10'd480; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;
        repeat (8) @(posedge clk);
        #1;
        btn_up_l = 0; btn_dn_l = 0; btn_up_r = 0; btn_dn_r = 0;
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        @(posedge clk); #1;
        btn_start = 1'b0;
        model_start();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " paddle_l_y"}, paddle_l_y, 204);
        check({tag, " paddle_r_y"}, paddle_r_y, 204);
        check({tag, " ball_x"}, ball_x, 316);
        check({tag, " ball_y"}, ball_y, 236);
        check({tag, " scores"}, {score_l, score_r}, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " game_over"}, game_over, 0);
    endtask

    // Monitor: every completed update sequence must last 4 cycles and match the model.
    initial begin
        bit    prev_busy;
        int    busy_len;
        snap_t act, exp;
        prev_busy = 0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 0;
                busy_len  = 0;
            end else begin
                if (busy) begin
                    busy_len++;
                end else if (prev_busy) begin
                    busy_pulses++;
                    check("busy length", busy_len, 4);
                    busy_len = 0;
                    act.pl = paddle_l_y; act.pr = paddle_r_y; act.bx = ball_x; act.by = ball_y;
                    act.sl = score_l; act.sr = score_r; act.go = game_over;
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame unexpected: busy pulse %0d with no expected frame", busy_pulses);
                    end else begin
                        exp = sb_q.pop_front();
                        if (act != exp) begin
                            n_fail++;
                            $display("FAIL frame %0d: got pl=%0d pr=%0d b=(%0d,%0d) s=%0d:%0d go=%0d, expected pl=%0d pr=%0d b=(%0d,%0d) s=%0d:%0d go=%0d",
                                     busy_pulses, act.pl, act.pr, act.bx, act.by, act.sl, act.sr, act.go,
                                     exp.pl, exp.pr, exp.bx, exp.by, exp.sl, exp.sr, exp.go);
                        end
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bp;
        int guard;
        int mark;
        bit seen1;
        bit ur;

        reset = 1'b0; p_tick = 0; pixel_x = 10'd5; pixel_y = 10'd5;
        btn_up_l = 0; btn_dn_l = 0; btn_up_r = 0; btn_dn_r = 0; btn_start = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        bp = busy_pulses;
        do_tick(0, 0, 0, 0);
        check("idle tick ignored", busy_pulses, bp);

        pulse_start();
        bp = busy_pulses;
        pixel_x = 10'd0; pixel_y = 10'd480; p_tick = 1'b0;
        @(posedge clk); #1;
        pixel_x = 10'd1; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;
        repeat (8) @(posedge clk);
        #1;
        check("unqualified tick ignored", busy_pulses, bp);

        do_tick(0, 0, 0, 0);
        check("qualified tick runs", busy_pulses, bp + 1);

        for (int t = 2; t <= 52; t++) do_tick(1, 0, 1, 1);
        check("left paddle at top", paddle_l_y, 0);
        check("right both pressed", paddle_r_y, 204);
        for (int t = 53; t <= 60; t++) do_tick(1, 0, 0, 1);
        check("left paddle held at 0", paddle_l_y, 0);
        check("ball centred in serve", ball_x, 316);

        do_tick(1, 0, 0, 1);
        check("first play ball_x", ball_x, 318);
        check("first play ball_y", ball_y, 238);
        for (int n = 2; n <= 46; n++) do_tick(1, 0, 0, 1);
        check("right paddle at bottom", paddle_r_y, 408);

        for (int n = 47; n <= 120; n++) begin
            do_tick(0, 0, 0, 0);
            if (n == 118) begin
                check("wall reach ball_y", ball_y, 472);
                check("wall reach ball_x", ball_x, 552);
            end
            if (n == 119) check("wall bounce ball_y", ball_y, 472);
            if (n == 120) check("after bounce ball_y", ball_y, 470);
        end

        guard = 0;
        mark  = 0;
        seen1 = 0;
        while (m_game != G_OVER && guard < 3000) begin
            ur = (m_by >= 236);
            do_tick(0, 0, ur, !ur);
            guard++;
            if (m_sl == 1 && !seen1) begin
                seen1 = 1;
                mark  = guard;
                check("point1 score_l", score_l, 1);
                check("point1 ball_x", ball_x, 316);
                check("point1 ball_y", ball_y, 236);
            end
            if (seen1 && guard == mark + 61) check("reserve heads right", ball_x, 318);
        end
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL rally budget: game not over after %0d ticks", guard);
        end
        check("game_over set", game_over, 1);
        check("final score_l", score_l, 9);
        check("final score_r", score_r, 0);

        bp = busy_pulses;
        do_tick(1, 0, 1, 0);
        check("over tick ignored", busy_pulses, bp);
        check("over ball frozen", ball_x, 316);

        pulse_start();
        check("restart score_l", score_l, 0);
        check("restart game_over", game_over, 0);
        bp = busy_pulses;
        do_tick(0, 0, 0, 0);
        check("restart serve runs", busy_pulses, bp + 1);

        pixel_x = 10'd0; pixel_y = 10'd480; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;
        @(posedge clk); #2;
        check("busy before reset", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_vals("midseq reset");
        sb_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bp = busy_pulses;
        do_tick(0, 0, 0, 0);
        check("idle after reset", busy_pulses, bp);

        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
